// File: rtl/board_scanner.sv
// board_scanner: walks the 64 playing cells of a walled 10x10 board memory,
// streams each cell out over a valid/ready port and tallies the pieces.
// Ports:
//   clock, reset           - rising-edge clock, async active-low reset
//   start                  - begin a full-board scan (honoured only when idle)
//   addr_to_mem, rden      - board memory read port (data one cycle after rden)
//   data_fr_mem            - cell contents: 00 null, 01 black, 10 white, 11 wall
//   cell_valid/cell_ready  - handshake for cell_idx (row*8+col) and cell_data
//   black_count/white_count- running piece totals
//   busy, done             - scan in progress / one-cycle completion pulse
//   board_full, winner     - final-result flags, valid after done
//   bad_cell               - sticky: a playing cell read back as wall
module board_scanner #(
    parameter int BASE_ADDR  = 11,
    parameter int ROW_STRIDE = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [6:0] addr_to_mem,
    output logic       rden,
    input  logic [1:0] data_fr_mem,
    output logic       cell_valid,
    input  logic       cell_ready,
    output logic [5:0] cell_idx,
    output logic [1:0] cell_data,
    output logic [6:0] black_count,
    output logic [6:0] white_count,
    output logic       busy,
    output logic       done,
    output logic       board_full,
    output logic [1:0] winner,
    output logic       bad_cell
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] idx;
    logic [5:0] idx_nxt;
    logic [6:0] addr_nxt;
    logic [6:0] total;
    logic       accept_start;

    // Row/column split of the index maps onto the bordered memory layout.
    assign addr_nxt = 7'(BASE_ADDR)
                    + 7'(idx_nxt[5:3]) * 7'(ROW_STRIDE)
                    + 7'(idx_nxt[2:0]);

    assign total        = black_count + white_count;
    assign accept_start = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        rden      = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ADDR;
                    idx_nxt   = 6'd0;
                end
            end
            ADDR: begin
                rden      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = EMIT;
            end
            EMIT: begin
                if (cell_ready) begin
                    if (idx == 6'd63) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 6'd1;
                        state_nxt = ADDR;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= 6'd0;
            addr_to_mem <= 7'd0;
            cell_valid  <= 1'b0;
            cell_idx    <= 6'd0;
            cell_data   <= 2'b00;
            black_count <= 7'd0;
            white_count <= 7'd0;
            board_full  <= 1'b0;
            winner      <= 2'b00;
            bad_cell    <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;

            // Address is registered on entry to ADDR and held elsewhere.
            if (state_nxt == ADDR) begin
                addr_to_mem <= addr_nxt;
            end

            if (accept_start) begin
                black_count <= 7'd0;
                white_count <= 7'd0;
                bad_cell    <= 1'b0;
            end

            if (state == WAIT) begin
                cell_data  <= data_fr_mem;
                cell_idx   <= idx;
                cell_valid <= 1'b1;
                unique case (data_fr_mem)
                    2'b01:   black_count <= black_count + 7'd1;
                    2'b10:   white_count <= white_count + 7'd1;
                    2'b11:   bad_cell    <= 1'b1;
                    default: ;
                endcase
            end

            if (state == EMIT && cell_ready) begin
                cell_valid <= 1'b0;
            end

            // Counts are final once the last cell is handed off.
            if (state_nxt == DONE) begin
                board_full <= (total == 7'd64);
                if (black_count > white_count) begin
                    winner <= 2'b01;
                end else if (white_count > black_count) begin
                    winner <= 2'b10;
                end else begin
                    winner <= 2'b00;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_scanner.sv
// tb_board_scanner: directed scans of board_scanner against a walled
// board memory model with hand-computed expected results.
module tb_board_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       cell_ready = 1'b1;
    logic [6:0] addr_to_mem;
    logic       rden;
    logic [1:0] data_fr_mem;
    logic       cell_valid;
    logic [5:0] cell_idx;
    logic [1:0] cell_data;
    logic [6:0] black_count;
    logic [6:0] white_count;
    logic       busy;
    logic       done;
    logic       board_full;
    logic [1:0] winner;
    logic       bad_cell;

    board_scanner dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .addr_to_mem (addr_to_mem),
        .rden        (rden),
        .data_fr_mem (data_fr_mem),
        .cell_valid  (cell_valid),
        .cell_ready  (cell_ready),
        .cell_idx    (cell_idx),
        .cell_data   (cell_data),
        .black_count (black_count),
        .white_count (white_count),
        .busy        (busy),
        .done        (done),
        .board_full  (board_full),
        .winner      (winner),
        .bad_cell    (bad_cell)
    );

    always #5 clock = ~clock;

    logic [1:0] mem [0:127];
    logic [1:0] mem_q = 2'b00;
    assign data_fr_mem = mem_q;

    always @(posedge clock) begin
        if (rden) mem_q <= mem[addr_to_mem];
    end

    int         total = 0;
    int         bad = 0;
    logic [6:0] addr_log [0:2047];
    int         addr_n = 0;
    logic [1:0] seen [0:63];
    logic       prev_bad = 1'b0;
    int         bad_drops = 0;

    always @(negedge clock) begin
        if (rden && addr_n < 2048) begin
            addr_log[addr_n] = addr_to_mem;
            addr_n = addr_n + 1;
        end
        if (cell_valid && cell_ready) seen[cell_idx] = cell_data;
        if (prev_bad && !bad_cell && busy) bad_drops = bad_drops + 1;
        prev_bad = bad_cell;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] caddr(input int i);
        return 7'(11 + (i / 8) * 10 + (i % 8));
    endfunction

    task automatic board_clear();
        for (int a = 0; a < 128; a++) mem[a] = 2'b11;
        for (int i = 0; i < 64; i++) mem[caddr(i)] = 2'b00;
    endtask

    task automatic put(input int i, input logic [1:0] v);
        mem[caddr(i)] = v;
    endtask

    task automatic scan(input int stall_at, input logic [1:0] stall_exp,
                        input int dup_at, output int cyc);
        int holds;
        holds = 0;
        @(negedge clock);
        start = 1'b1;
        cell_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            start = (cyc == dup_at);
            cell_ready = !(stall_at >= 0 && cell_valid &&
                           cell_idx == 6'(stall_at) && holds < 5);
            @(posedge clock);
            #1;
            cyc++;
            if (!cell_ready) begin
                holds++;
                chk("stall_valid", cell_valid, 1);
                chk("stall_idx", cell_idx, stall_at);
                chk("stall_data", cell_data, stall_exp);
                chk("stall_rden", rden, 0);
            end
        end
        start = 1'b0;
        cell_ready = 1'b1;
        chk("done_seen", done, 1);
    endtask

    task automatic idle_check();
        @(posedge clock);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    int cyc;
    int base;
    int n;

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = 2'b11;
        for (int i = 0; i < 64; i++) seen[i] = 2'b00;
        #3;
        chk("rst_addr", addr_to_mem, 0);
        chk("rst_rden", rden, 0);
        chk("rst_valid", cell_valid, 0);
        chk("rst_idx", cell_idx, 0);
        chk("rst_data", cell_data, 0);
        chk("rst_black", black_count, 0);
        chk("rst_white", white_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", board_full, 0);
        chk("rst_winner", winner, 0);
        chk("rst_bad", bad_cell, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Empty board: address order and latency.
        board_clear();
        base = addr_n;
        scan(-1, 2'b00, -1, cyc);
        chk("empty_cycles", cyc, 193);
        chk("empty_black", black_count, 0);
        chk("empty_white", white_count, 0);
        chk("empty_winner", winner, 0);
        chk("empty_full", board_full, 0);
        chk("empty_nreads", addr_n - base, 64);
        for (int i = 0; i < 64 && base + i < addr_n; i++) begin
            chk($sformatf("empty_addr%0d", i), addr_log[base + i], caddr(i));
        end
        idle_check();

        // Full board 40 black / 24 white.
        board_clear();
        for (int i = 0; i < 40; i++) put(i, 2'b01);
        for (int i = 40; i < 64; i++) put(i, 2'b10);
        scan(-1, 2'b00, -1, cyc);
        chk("full_cycles", cyc, 193);
        chk("full_black", black_count, 40);
        chk("full_white", white_count, 24);
        chk("full_flag", board_full, 1);
        chk("full_winner", winner, 2'b01);
        chk("full_bad", bad_cell, 0);
        idle_check();
        chk("full_hold_flag", board_full, 1);
        chk("full_hold_black", black_count, 40);

        // Initial Othello position.
        board_clear();
        put(27, 2'b10);
        put(36, 2'b10);
        put(28, 2'b01);
        put(35, 2'b01);
        scan(-1, 2'b00, -1, cyc);
        chk("oth_black", black_count, 2);
        chk("oth_white", white_count, 2);
        chk("oth_winner", winner, 2'b00);
        chk("oth_full", board_full, 0);
        chk("oth_cell27", seen[27], 2'b10);
        chk("oth_cell28", seen[28], 2'b01);
        chk("oth_last_idx", cell_idx, 63);
        idle_check();

        // White leads.
        board_clear();
        put(0, 2'b10);
        put(1, 2'b10);
        put(2, 2'b10);
        put(63, 2'b01);
        scan(-1, 2'b00, -1, cyc);
        chk("wl_winner", winner, 2'b10);
        chk("wl_white", white_count, 3);
        chk("wl_last_data", cell_data, 2'b01);
        idle_check();

        // Back-pressure at cell 10 for five cycles.
        board_clear();
        put(10, 2'b01);
        scan(10, 2'b01, -1, cyc);
        chk("stall_cycles", cyc, 198);
        chk("stall_black", black_count, 1);
        idle_check();

        // Wall inside the board, plus a start pulse mid-scan.
        board_clear();
        put(5, 2'b11);
        put(6, 2'b01);
        put(7, 2'b10);
        n = bad_drops;
        scan(-1, 2'b00, 50, cyc);
        chk("badc_cycles", cyc, 193);
        chk("badc_flag", bad_cell, 1);
        chk("badc_drops", bad_drops - n, 0);
        chk("badc_black", black_count, 1);
        chk("badc_white", white_count, 1);
        chk("badc_seen5", seen[5], 2'b11);
        idle_check();
        chk("badc_hold", bad_cell, 1);

        // Asynchronous reset at cell 30.
        board_clear();
        put(2, 2'b11);
        for (int i = 3; i < 21; i++) put(i, 2'b01);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("rs_busy_on", busy, 1);
        n = 0;
        while (!(cell_valid && cell_idx == 6'd30) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("rs_reach30", cell_valid && cell_idx == 6'd30, 1);
        chk("rs_pre_black", black_count, 18);
        chk("rs_pre_bad", bad_cell, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_async_zero",
            {addr_to_mem, rden, cell_valid, cell_idx, cell_data,
             black_count, white_count, busy, done, board_full,
             winner, bad_cell}, 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (done || busy) n++;
        end
        chk("rs_no_done", n, 0);

        // Recovery after reset.
        board_clear();
        put(0, 2'b01);
        scan(-1, 2'b00, -1, cyc);
        chk("rec_cycles", cyc, 193);
        chk("rec_black", black_count, 1);
        chk("rec_winner", winner, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter BASE_ADDR, default 11, memory address of playing cell (row 0, col 0).
REQ-002 Parameter ROW_STRIDE, default 10, memory address distance between consecutive rows (board plus wall border).
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-005 start  in  1  request a full-board scan; sampled only in IDLE.
REQ-006 addr_to_mem  out  7  board memory read address.
REQ-007 rden  out  1  read strobe; memory returns data the cycle after rden is sampled high.
REQ-008 data_fr_mem  in  2  cell contents: 00 null, 01 black, 10 white, 11 wall.
REQ-009 cell_valid  out  1  cell_idx/cell_data hold a valid cell.
REQ-010 cell_ready  in  1  consumer accepts the cell on an edge where cell_valid=1.
REQ-011 cell_idx  out  6  playing-cell index, row*8+col.
REQ-012 cell_data  out  2  captured contents of cell_idx.
REQ-013 black_count, white_count  out  7 each  piece totals, 0..64.
REQ-014 busy  out  1  high from start acceptance until DONE exits.
REQ-015 done  out  1  one-cycle pulse at scan completion.
REQ-016 board_full  out  1  black_count+white_count==64, valid after done.
REQ-017 winner  out  2  00 tie, 01 black leads, 10 white leads; valid after done.
REQ-018 bad_cell  out  1  sticky; a playing cell read as 11.

Function
REQ-019 FSM states: IDLE, ADDR, WAIT, EMIT, DONE.
REQ-020 IDLE: start=1 -> clear idx, counts, bad_cell; go to ADDR; busy=1.
REQ-021 start while busy is ignored; scan continues unaffected.
REQ-022 ADDR (1 cycle): rden=1, addr_to_mem = BASE_ADDR + idx[5:3]*ROW_STRIDE + idx[2:0], computed 7 bits wide, no truncation for idx 0..63 at defaults (range 11..88); -> WAIT.
REQ-023 rden=0 in every state except ADDR; addr_to_mem holds its last value otherwise.
REQ-024 WAIT (1 cycle): at its closing edge capture data_fr_mem into cell_data, cell_idx<=idx, cell_valid<=1, increment black_count on 01, white_count on 10, set bad_cell on 11, null counts nothing; -> EMIT.
REQ-025 EMIT: hold cell_valid, cell_idx, cell_data stable until an edge with cell_ready=1; no further memory read issued.
REQ-026 EMIT accept: cell_valid<=0; idx==63 -> DONE, else idx<=idx+1 -> ADDR.
REQ-027 cell_ready=1 outside EMIT has no effect.
REQ-028 Minimum throughput 3 cycles per cell; scan with cell_ready tied high completes 193 cycles after start acceptance (done asserted in cycle 193).
REQ-029 DONE (1 cycle): done=1, board_full and winner updated from final counts; -> IDLE, busy=0.
REQ-030 Counts, cell_idx, cell_data, board_full, winner, bad_cell hold after done until the next accepted start.
REQ-031 Winner compares black_count vs white_count, unsigned 7-bit.
REQ-032 idx is 6 bits and never wraps; the 63 -> DONE transition is the only exit from the scan loop.

Reset
REQ-033 reset low, asynchronously: state IDLE; idx, addr_to_mem, cell_idx, cell_data, black_count, white_count, winner = 0; rden, cell_valid, busy, done, board_full, bad_cell = 0.
REQ-034 Reset mid-scan abandons the scan; no done pulse; after release the block waits in IDLE for a new start.

Verification
REQ-035 Empty board (all 00), cell_ready=1, start pulse -> addresses 11..18, 21..28, ..., 81..88 in order; done at cycle 193; counts 0/0; winner 00; board_full 0.
REQ-036 Initial Othello position (27,36 white; 28,35 black) -> black_count 2, white_count 2, winner 00; cell_data 10 at cell_idx 27.
REQ-037 Full board, 40 black / 24 white -> board_full 1, winner 01, bad_cell 0.
REQ-038 cell_ready low 5 cycles at cell 10 -> cell_valid, cell_idx 10, cell_data stable throughout; rden stays 0; scan resumes on acceptance.
REQ-039 Cell 5 reads 11 -> bad_cell 1 to end of scan; counts exclude it; second start during scan ignored; reset low at cell 30 -> all outputs 0 immediately, no done.
